// File: rtl/sbox_arbiter.sv
// rtl/sbox_arbiter.sv - one shared Rijndael S-box time-multiplexed between key-expansion and round datapath
// Requests are serialized one byte per clock; results are registered per client.
module sbox_arbiter (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_req_valid,
   output logic         key_req_ready,
   input  logic [31:0]  key_req_word,
   output logic         key_rsp_valid,
   output logic [31:0]  key_rsp_word,
   input  logic         st_req_valid,
   output logic         st_req_ready,
   input  logic [127:0] st_req_data,
   output logic         st_rsp_valid,
   output logic [127:0] st_rsp_data,
   output logic         busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SUB  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Element 0 is the most significant byte of the packed constant, so row 0 comes first.
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [1:0]   state;
   logic         prio_key;
   logic         client_st;
   logic [3:0]   cnt;
   logic [127:0] in_data;
   logic [31:0]  key_res;
   logic [127:0] st_res;
   logic [7:0]   sbox_in;
   logic [7:0]   sbox_out;
   logic         last_byte;
   logic         idle;

   assign idle          = (state == IDLE);
   assign busy          = ~idle;
   assign key_req_ready = idle & key_req_valid & (~st_req_valid | prio_key);
   assign st_req_ready  = idle & st_req_valid & (~key_req_valid | ~prio_key);

   assign sbox_in   = in_data[{cnt, 3'b000} +: 8];
   assign sbox_out  = SBOX_TABLE[sbox_in];
   assign last_byte = client_st ? (cnt == 4'd15) : (cnt == 4'd3);

   assign key_rsp_valid = (state == DONE) & ~client_st;
   assign st_rsp_valid  = (state == DONE) & client_st;
   assign key_rsp_word  = key_res;
   assign st_rsp_data   = st_res;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prio_key  <= 1'b1;
         client_st <= 1'b0;
         cnt       <= 4'd0;
         in_data   <= 128'd0;
         key_res   <= 32'd0;
         st_res    <= 128'd0;
      end else begin
         case (state)
            IDLE: begin
               if (key_req_ready) begin
                  in_data   <= {96'd0, key_req_word};
                  client_st <= 1'b0;
                  prio_key  <= 1'b0;
                  cnt       <= 4'd0;
                  state     <= SUB;
               end else if (st_req_ready) begin
                  in_data   <= st_req_data;
                  client_st <= 1'b1;
                  prio_key  <= 1'b1;
                  cnt       <= 4'd0;
                  state     <= SUB;
               end
            end
            SUB: begin
               // Only the byte under the counter changes; the rest of the result is held.
               if (client_st)
                  st_res[{cnt, 3'b000} +: 8] <= sbox_out;
               else
                  key_res[{cnt[1:0], 3'b000} +: 8] <= sbox_out;
               cnt <= cnt + 4'd1;
               if (last_byte)
                  state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
